// File: rtl/rv32i_fetch_queue_pkg.sv
// Shared types and constants for the RV32I instruction fetch queue.
// One queue entry holds a fetch PC, its returned word and a completion flag.
package rv32i_pkg;

  localparam int XLEN = 32;
  localparam logic [31:0] RV32I_NOP = 32'h0000_0013;

  typedef struct packed {
    logic        done;
    logic [31:0] pc;
    logic [31:0] instr;
  } fq_entry_t;

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/rv32i_fetch_queue_if.sv
// Instruction-memory read bus: request/grant on the way out, in-order data on the way back.
// The fetch queue is the master; the memory is the slave.
interface rv32i_fetch_queue_if #(parameter int WIDTH = 32);

  logic             req;
  logic [WIDTH-1:0] addr;
  logic             gnt;
  logic             rvalid;
  logic [WIDTH-1:0] rdata;

  modport master (output req, output addr, input gnt, input rvalid, input rdata);
  modport slave  (input req, input addr, output gnt, output rvalid, output rdata);

endinterface

// File: rtl/rv32i_fq_ptrs.sv
// Alloc/fill/read pointers, discard counter and fetch credit for the fetch queue.
// Pointers carry one extra wrap bit so full and empty are distinguishable.
module rv32i_fq_ptrs #(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_pc_valid,
  input  logic                     i_gnt,
  input  logic                     i_rvalid,
  input  logic                     i_pop,
  input  logic                     i_flush,
  output logic                     o_req,
  output logic                     o_grant,
  output logic                     o_fill_en,
  output logic                     o_not_empty,
  output logic [$clog2(DEPTH)-1:0] o_alloc_idx,
  output logic [$clog2(DEPTH)-1:0] o_fill_idx,
  output logic [$clog2(DEPTH)-1:0] o_rd_idx
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW+1:0] LP_DEPTH = (PW+2)'(DEPTH);

  logic [PW:0]   r_alloc;
  logic [PW:0]   r_fill;
  logic [PW:0]   r_rd;
  logic [PW:0]   r_discard;
  logic [PW:0]   w_occ;
  logic [PW:0]   w_pending;
  logic [PW:0]   w_discard_add;
  logic [PW+1:0] w_used;
  logic          w_eat;

  assign w_occ     = r_alloc - r_rd;
  assign w_pending = r_alloc - r_fill;
  assign w_used    = {1'b0, w_occ} + {1'b0, r_discard};

  // Held low while in reset so the bus is quiet regardless of i_pc_valid.
  assign o_req       = rst & i_pc_valid & (w_used < LP_DEPTH) & ~i_flush;
  assign o_grant     = o_req & i_gnt;
  assign o_fill_en   = i_rvalid & (r_discard == '0) & (w_pending != '0) & ~i_flush;
  assign o_not_empty = (w_occ != '0);
  assign o_alloc_idx = r_alloc[PW-1:0];
  assign o_fill_idx  = r_fill[PW-1:0];
  assign o_rd_idx    = r_rd[PW-1:0];

  // A returning word is swallowed if it belongs to an older flush, or to the
  // reads being flushed right now; discard + pending always tracks reads in flight.
  assign w_eat         = i_rvalid & ((r_discard != '0) | (i_flush & (w_pending != '0)));
  assign w_discard_add = i_flush ? w_pending : '0;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_alloc   <= '0;
      r_fill    <= '0;
      r_rd      <= '0;
      r_discard <= '0;
    end else begin
      r_discard <= r_discard + w_discard_add - (PW+1)'(w_eat);
      if (i_flush) begin
        r_alloc <= r_fill;
        r_rd    <= r_fill;
      end else begin
        r_alloc <= r_alloc + (PW+1)'(o_grant);
        r_fill  <= r_fill + (PW+1)'(o_fill_en);
        r_rd    <= r_rd + (PW+1)'(i_pop);
      end
    end
  end

  a_rvalid_has_owner: assert property (@(posedge clk) disable iff (!rst)
    i_rvalid |-> ((w_pending != '0) || (r_discard != '0)));

endmodule

// File: rtl/rv32i_fetch_queue.sv
// Fetch queue between the PC stage and decode: issues in-order imem reads,
// buffers returned words and hands {pc, instr} pairs to decode; flushable on redirect.
module rv32i_fetch_queue
  import rv32i_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [WIDTH-1:0]           i_pc,
  input  logic                       i_pc_valid,
  output logic                       o_pc_ready,
  rv32i_fetch_queue_if.master        imem,
  output logic                       o_instr_valid,
  output logic [WIDTH-1:0]           o_instr,
  output logic [WIDTH-1:0]           o_instr_pc,
  input  logic                       i_instr_ready,
  input  logic                       i_flush
);

  localparam int PW = $clog2(DEPTH);

  fq_entry_t     r_q [DEPTH];
  fq_entry_t     w_head;
  logic          w_req;
  logic          w_grant;
  logic          w_fill_en;
  logic          w_not_empty;
  logic          w_pop;
  logic [PW-1:0] w_alloc_idx;
  logic [PW-1:0] w_fill_idx;
  logic [PW-1:0] w_rd_idx;

  rv32i_fq_ptrs #(.DEPTH(DEPTH)) u_ptrs (
    .clk         (clk),
    .rst         (rst),
    .i_pc_valid  (i_pc_valid),
    .i_gnt       (imem.gnt),
    .i_rvalid    (imem.rvalid),
    .i_pop       (w_pop),
    .i_flush     (i_flush),
    .o_req       (w_req),
    .o_grant     (w_grant),
    .o_fill_en   (w_fill_en),
    .o_not_empty (w_not_empty),
    .o_alloc_idx (w_alloc_idx),
    .o_fill_idx  (w_fill_idx),
    .o_rd_idx    (w_rd_idx)
  );

  assign imem.req   = w_req;
  assign imem.addr  = word_align(i_pc);
  assign o_pc_ready = w_grant;

  // Stale done bits in freed slots are masked by the occupancy check.
  assign w_head        = r_q[w_rd_idx];
  assign o_instr_valid = w_not_empty & w_head.done & ~i_flush;
  assign w_pop         = o_instr_valid & i_instr_ready;
  assign o_instr       = o_instr_valid ? w_head.instr : RV32I_NOP;
  assign o_instr_pc    = o_instr_valid ? w_head.pc : '0;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_q[i] <= '0;
      end
    end else if (i_flush) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_q[i].done <= 1'b0;
      end
    end else begin
      if (w_grant) begin
        r_q[w_alloc_idx].pc   <= i_pc;
        r_q[w_alloc_idx].done <= 1'b0;
      end
      if (w_fill_en) begin
        r_q[w_fill_idx].instr <= imem.rdata;
        r_q[w_fill_idx].done  <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_rv32i_fetch_queue.sv
// Randomised scoreboard bench for rv32i_fetch_queue: a queue-level reference model
// predicts handshakes each cycle, a separate monitor checks every delivered instruction.
module tb_rv32i_fetch_queue;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] i_pc;
  logic        i_pc_valid;
  logic        o_pc_ready;
  logic        o_instr_valid;
  logic [31:0] o_instr;
  logic [31:0] o_instr_pc;
  logic        i_instr_ready;
  logic        i_flush;

  always #5 clk = ~clk;

  rv32i_fetch_queue_if #(.WIDTH(32)) imem ();

  rv32i_fetch_queue #(.WIDTH(32), .DEPTH(DEPTH)) dut (
    .clk           (clk),
    .rst           (rst),
    .i_pc          (i_pc),
    .i_pc_valid    (i_pc_valid),
    .o_pc_ready    (o_pc_ready),
    .imem          (imem),
    .o_instr_valid (o_instr_valid),
    .o_instr       (o_instr),
    .o_instr_pc    (o_instr_pc),
    .i_instr_ready (i_instr_ready),
    .i_flush       (i_flush)
  );

  // Reference model: accepted fetches not yet consumed, and reads still out at memory.
  typedef struct { logic [31:0] pc; bit arrived; } ent_t;
  typedef struct { logic [31:0] addr; int due; bit stale; } rd_t;
  typedef struct { logic [31:0] pc; logic [31:0] instr; } exp_t;

  ent_t ent[$];
  rd_t  mq[$];
  exp_t sb_q[$];

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int dut_grants = 0;
  int deliv_cnt = 0;
  logic [31:0] last_pc = '0;
  logic [31:0] next_pc = '0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    logic [31:0] w;
    w = {a[31:2], 2'b00};
    return (w * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d actual=%h required=%h", name, cyc, act, exp);
    end
  endtask

  task automatic chk_reset_outputs();
    chk("rst_instr_valid", 32'(o_instr_valid), 32'd0);
    chk("rst_imem_req", 32'(imem.req), 32'd0);
    chk("rst_pc_ready", 32'(o_pc_ready), 32'd0);
    chk("rst_instr", o_instr, 32'h0000_0013);
    chk("rst_instr_pc", o_instr_pc, 32'd0);
  endtask

  // One clock of stimulus: drive at negedge, check predicted handshakes, advance the model.
  task automatic step(input bit pv, input bit gn, input bit rdy, input bit fl,
                      input bit mem_en, input int lat);
    bit head_v, req_e, grant_e, rv;
    int stale_n;
    @(negedge clk);
    rv = mem_en && (mq.size() > 0) && (mq[0].due <= cyc);
    imem.rvalid   = rv;
    imem.rdata    = rv ? mem_word(mq[0].addr) : $urandom;
    imem.gnt      = gn;
    i_pc_valid    = pv;
    i_pc          = next_pc;
    i_instr_ready = rdy;
    i_flush       = fl;
    #1;
    stale_n = 0;
    foreach (mq[k]) if (mq[k].stale) stale_n++;
    head_v  = (ent.size() > 0) && ent[0].arrived && !fl;
    req_e   = pv && ((ent.size() + stale_n) < DEPTH) && !fl;
    grant_e = req_e && gn;
    chk("imem_req", 32'(imem.req), 32'(req_e));
    chk("pc_ready", 32'(o_pc_ready), 32'(grant_e));
    if (req_e) chk("imem_addr", imem.addr, {next_pc[31:2], 2'b00});
    chk("instr_valid", 32'(o_instr_valid), 32'(head_v));
    chk("instr", o_instr, head_v ? mem_word(ent[0].pc) : 32'h0000_0013);
    if (o_pc_ready) dut_grants++;

    if (head_v && rdy) void'(ent.pop_front());
    if (rv) begin
      if (!mq[0].stale && !fl) begin
        for (int k = 0; k < ent.size(); k++) begin
          if (!ent[k].arrived) begin
            ent[k].arrived = 1'b1;
            break;
          end
        end
      end
      void'(mq.pop_front());
    end
    if (fl) begin
      foreach (mq[k]) mq[k].stale = 1'b1;
      ent.delete();
      sb_q.delete();
    end
    if (grant_e) begin
      ent.push_back('{pc: next_pc, arrived: 1'b0});
      mq.push_back('{addr: imem.addr, due: cyc + 1 + lat, stale: 1'b0});
      sb_q.push_back('{pc: next_pc, instr: mem_word(next_pc)});
      next_pc = next_pc + 32'd4;
    end
    cyc++;
  endtask

  // Monitor: every decode handshake the DUT shows must match the scoreboard head.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (rst && o_instr_valid && i_instr_ready) begin
        deliv_cnt++;
        last_pc = o_instr_pc;
        if (sb_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL deliver_unexpected cyc=%0d actual pc=%h required none", cyc, o_instr_pc);
        end else begin
          e = sb_q.pop_front();
          chk("deliver_pc", o_instr_pc, e.pc);
          chk("deliver_instr", o_instr, e.instr);
          $display("deliver pc=%h instr=%h", o_instr_pc, o_instr);
        end
      end
    end
  end

  initial begin
    int g0, d0;
    bit fl;

    i_pc = 32'h40; i_pc_valid = 1'b1; i_instr_ready = 1'b1; i_flush = 1'b0;
    imem.gnt = 1'b1; imem.rvalid = 1'b1; imem.rdata = 32'hDEAD_BEEF;
    rst = 1'b0;
    repeat (3) @(negedge clk);
    #1 chk_reset_outputs();
    @(negedge clk);
    rst = 1'b1; i_pc_valid = 1'b0; imem.gnt = 1'b0; imem.rvalid = 1'b0;
    #1;
    chk("post_rst_instr", o_instr, 32'h0000_0013);
    chk("post_rst_valid", 32'(o_instr_valid), 32'd0);

    // Stream of four PCs through a 1-cycle memory
    next_pc = 32'h0;
    d0 = deliv_cnt;
    for (int i = 0; i < 8; i++) step(i < 4, 1, 1, 0, 1, 0);
    chk("stream_count", 32'(deliv_cnt - d0), 32'd4);
    chk("stream_last_pc", last_pc, 32'hC);

    // Backpressure: fill to DEPTH, one pop frees a slot only a cycle later
    g0 = dut_grants;
    for (int i = 0; i < 8; i++) step(1, 1, 0, 0, 1, 0);
    chk("bp_grants", 32'(dut_grants - g0), 32'd4);
    step(1, 1, 1, 0, 1, 0);
    chk("bp_pop_cycle", 32'(dut_grants - g0), 32'd4);
    step(1, 1, 0, 0, 1, 0);
    chk("bp_regrant", 32'(dut_grants - g0), 32'd5);
    for (int i = 0; i < 10; i++) step(0, 0, 1, 0, 1, 0);

    // Flush with one buffered word and two reads in flight
    step(1, 1, 0, 0, 1, 0);
    step(1, 1, 0, 0, 1, 5);
    step(1, 1, 0, 0, 1, 5);
    step(1, 0, 1, 1, 1, 0);
    next_pc = 32'h100;
    d0 = deliv_cnt;
    step(1, 1, 1, 0, 1, 0);
    for (int i = 0; i < 12; i++) step(0, 0, 1, 0, 1, 0);
    chk("flush_deliv", 32'(deliv_cnt - d0), 32'd1);
    chk("flush_pc", last_pc, 32'h100);

    // Flush coinciding with the only outstanding rvalid
    next_pc = 32'h200;
    g0 = dut_grants;
    d0 = deliv_cnt;
    step(1, 1, 0, 0, 1, 0);
    step(0, 0, 1, 1, 1, 0);
    step(1, 1, 1, 0, 1, 0);
    chk("flush_rv_regrant", 32'(dut_grants - g0), 32'd2);
    for (int i = 0; i < 6; i++) step(0, 0, 1, 0, 1, 0);
    chk("flush_rv_deliv", 32'(deliv_cnt - d0), 32'd1);
    chk("flush_rv_pc", last_pc, 32'h204);

    // Randomised traffic with occasional redirects to arbitrary PCs
    for (int i = 0; i < 2000; i++) begin
      fl = ($urandom_range(0, 99) < 4);
      step($urandom_range(0, 9) < 7, $urandom_range(0, 9) < 7, $urandom_range(0, 9) < 6,
           fl, $urandom_range(0, 9) < 7, int'($urandom_range(0, 3)));
      if (fl) next_pc = $urandom;
    end

    // Reset in the middle of a stream
    next_pc = 32'h300;
    for (int i = 0; i < 3; i++) step(1, 1, 0, 0, 1, 2);
    @(negedge clk);
    rst = 1'b0; i_pc_valid = 1'b1; imem.gnt = 1'b1; i_instr_ready = 1'b1;
    #1 chk_reset_outputs();
    @(negedge clk);
    #1 chk_reset_outputs();
    mq.delete(); ent.delete(); sb_q.delete();
    next_pc = 32'h0;
    @(negedge clk);
    rst = 1'b1; i_pc_valid = 1'b0; imem.gnt = 1'b0; imem.rvalid = 1'b0;
    d0 = deliv_cnt;
    for (int i = 0; i < 8; i++) step(i < 4, 1, 1, 0, 1, 0);
    chk("rst_restart_count", 32'(deliv_cnt - d0), 32'd4);
    chk("rst_restart_last_pc", last_pc, 32'hC);

    for (int i = 0; i < 20; i++) step(0, 0, 1, 0, 1, 0);
    chk("scoreboard_drained", 32'(sb_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
